// File: rtl/alu_mc_if.sv
// Request/response handshake bundle for the multi-cycle execute unit.
// The issue side drives the master modport; alu_mc sits on the slave modport.
interface alu_mc_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [WIDTH-1:0] in_src1;
  logic [WIDTH-1:0] in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute unit: single-cycle ALU ops plus MUL*/DIV*, one op in flight.
// Optional DIV_EARLY_EXIT_EN: divide by zero or |src1|<|src2| finishes at cycle 2.
module alu_mc #(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 4,
  parameter int MUL_STAGES = 2
) (
  input logic    clk,
  input logic    resetn,
  input logic    flush,
  alu_mc_if.slave bus
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + MUL_STAGES + 1);

  localparam logic [4:0] OP_OUT2 = 5'd0,  OP_ADD  = 5'd1,  OP_SUB   = 5'd2,  OP_EQU   = 5'd3;
  localparam logic [4:0] OP_SLT  = 5'd4,  OP_SLTU = 5'd5,  OP_AND   = 5'd6,  OP_NOR   = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8,  OP_XOR  = 5'd9,  OP_SLL   = 5'd10, OP_SRL   = 5'd11;
  localparam logic [4:0] OP_SRA  = 5'd12, OP_MUL  = 5'd13, OP_MULH  = 5'd14, OP_MULHU = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16, OP_DIVU = 5'd17, OP_MOD   = 5'd18, OP_MODU  = 5'd19;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic               accept;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   m1, m2, q_fix, r_fix;
  logic               sgn;

  function automatic logic [WIDTH-1:0] simple_res(input logic [4:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [SH_W-1:0] sh;
    sh = b[SH_W-1:0];
    case (op)
      OP_OUT2: return b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_EQU:  return {{(WIDTH-1){1'b0}}, a == b};
      OP_SLT:  return {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: return {{(WIDTH-1){1'b0}}, a < b};
      OP_AND:  return a & b;
      OP_NOR:  return ~(a | b);
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return WIDTH'($signed(a) >>> sh);
      default: return a;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] mul_res(input logic [4:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] pu, ps;
    pu = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    ps = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    case (op)
      OP_MULH:  return ps[2*WIDTH-1:WIDTH];
      OP_MULHU: return pu[2*WIDTH-1:WIDTH];
      default:  return pu[WIDTH-1:0];
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  assign bus.in_ready   = (state_q == S_IDLE) && !flush;
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_result = res_q;
  assign bus.out_tag    = tag_q;
  assign accept         = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    trial   = '0;
    m1      = '0;
    m2      = '0;
    q_fix   = '0;
    r_fix   = '0;
    sgn     = 1'b0;

    case (state_q)
      S_IDLE: if (accept) begin
        op_d  = bus.in_op;
        a_d   = bus.in_src1;
        b_d   = bus.in_src2;
        tag_d = bus.in_tag;
        if (bus.in_op inside {OP_MUL, OP_MULH, OP_MULHU}) begin
          if (MUL_STAGES == 1) begin
            res_d   = mul_res(bus.in_op, bus.in_src1, bus.in_src2);
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_W'(MUL_STAGES - 2);
            state_d = S_MUL;
          end
        end else if (bus.in_op inside {[OP_DIV:OP_MODU]}) begin
          sgn     = (bus.in_op == OP_DIV) || (bus.in_op == OP_MOD);
          m1      = mag(bus.in_src1, sgn);
          m2      = mag(bus.in_src2, sgn);
          quo_d   = m1;
          rem_d   = '0;
          dvs_d   = m2;
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_DIV;
`ifdef DIV_EARLY_EXIT_EN
          // Quotient is already known to be 0 (or overridden for /0); go straight to fixup.
          if (m2 == '0 || m1 < m2) begin
            quo_d = '0;
            rem_d = m1;
            cnt_d = '0;
          end
`endif
        end else begin
          res_d   = simple_res(bus.in_op, bus.in_src1, bus.in_src2);
          state_d = S_DONE;
        end
      end

      S_MUL: begin
        if (cnt_q == '0) begin
          res_d   = mul_res(op_q, a_q, b_q);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DIV: begin
        if (cnt_q != '0) begin
          // Restoring step: quo_q shifts dividend bits into rem while collecting quotient bits.
          trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          sgn   = (op_q == OP_DIV) || (op_q == OP_MOD);
          q_fix = (sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
          r_fix = (sgn && a_q[WIDTH-1]) ? -rem_q : rem_q;
          if (b_q == '0) begin
            q_fix = '1;
            r_fix = a_q;
          end
          res_d   = (op_q == OP_DIV || op_q == OP_DIVU) ? q_fix : r_fix;
          state_d = S_DONE;
        end
      end

      S_DONE: if (bus.out_ready) state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Directed + randomized bench for alu_mc against an arithmetic reference model.
// Expected latency follows DIV_EARLY_EXIT_EN when the build defines it.
module tb_alu_mc;
  localparam int W  = 32;
  localparam int TW = 4;
  localparam int MS = 3;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W), .TAG_W(TW)) bus ();
  alu_mc #(.WIDTH(W), .TAG_W(TW), .MUL_STAGES(MS)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ref_res(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    int              sh = int'(b[4:0]);
    longint          ps;
    longint unsigned pu;
    ps = sa * sb;
    pu = ua * ub;
    case (op)
      0:  return b;
      1:  return W'(ua + ub);
      2:  return W'(ua - ub);
      3:  return (a == b) ? W'(1) : W'(0);
      4:  return (sa < sb) ? W'(1) : W'(0);
      5:  return (ua < ub) ? W'(1) : W'(0);
      6:  return a & b;
      7:  return ~(a | b);
      8:  return a | b;
      9:  return a ^ b;
      10: return W'(ua << sh);
      11: return W'(ua >> sh);
      12: return W'(sa >>> sh);
      13: return W'(pu);
      14: return W'(ps >>> 32);
      15: return W'(pu >> 32);
      16: return (b == 0) ? '1 : W'(sa / sb);
      17: return (b == 0) ? '1 : W'(ua / ub);
      18: return (b == 0) ? a  : W'(sa % sb);
      19: return (b == 0) ? a  : W'(ua % ub);
      default: return a;
    endcase
  endfunction

  function automatic int exp_lat(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ma, mb;
    if (op >= 13 && op <= 15) return MS;
    if (op >= 16 && op <= 19) begin
      if (op == 16 || op == 18) begin
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
      end else begin
        ma = longint'(a);
        mb = longint'(b);
      end
`ifdef DIV_EARLY_EXIT_EN
      if (mb == 0 || ma < mb) return 2;
`endif
      return W + 2;
    end
    return 1;
  endfunction

  // Issue one op with out_ready high; check latency, result, tag and return to idle.
  task automatic run_op(input string name, input int op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] tag);
    logic [W-1:0] e;
    int lat, k;
    e   = ref_res(op, a, b);
    lat = exp_lat(op, a, b);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 5'(op); bus.in_src1 = a; bus.in_src2 = b;
    bus.in_tag = tag; bus.out_ready = 1'b1;
    check({name, " in_ready"}, 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    k = 1;
    while (!bus.out_valid && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check({name, " latency"}, 64'(k), 64'(lat));
    check({name, " result"}, 64'(bus.out_result), 64'(e));
    check({name, " tag"}, 64'(bus.out_tag), 64'(tag));
    @(posedge clk); #1;
    check({name, " idle"}, 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    int k, highs;
    logic [W-1:0] ra, rb;
    int rop;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_src1 = '0; bus.in_src2 = '0;
    bus.in_tag = '0; bus.out_ready = 1'b1;

    #2;
    check("reset out_valid", 64'(bus.out_valid), 64'(0));
    check("reset out_result", 64'(bus.out_result), 64'(0));
    check("reset out_tag", 64'(bus.out_tag), 64'(0));
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    run_op("add_ovf", 1, 32'h7FFF_FFFF, 32'h1, 4'h5);
    run_op("sra", 12, 32'hF000_0000, 32'd4, 4'hA);
    run_op("mulh", 14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h1);
    run_op("mulhu", 15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2);
    run_op("mul", 13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3);
    run_op("div_neg", 16, 32'hFFFF_FFF9, 32'd2, 4'h4);
    run_op("mod_neg", 18, 32'hFFFF_FFF9, 32'd2, 4'h6);
    run_op("divu", 17, 32'd100, 32'd7, 4'h7);
    run_op("div_min", 16, MIN, 32'hFFFF_FFFF, 4'h8);
    run_op("mod_min", 18, MIN, 32'hFFFF_FFFF, 4'h9);
    run_op("divu_z", 17, 32'd5, 32'd0, 4'hB);
    run_op("modu_z", 19, 32'd5, 32'd0, 4'hC);
    run_op("div_z", 16, 32'hFFFF_FFF0, 32'd0, 4'hD);
    run_op("mod_small", 18, 32'hFFFF_FFFD, 32'd9, 4'hE);

    // Back-pressure: result and tag must hold while out_ready is low.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 5'd1; bus.in_src1 = 32'd5; bus.in_src2 = 32'd6;
    bus.in_tag = 4'h9; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("hold first valid", 64'(bus.out_valid), 64'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold valid", 64'(bus.out_valid), 64'(1));
      check("hold result", 64'(bus.out_result), 64'(11));
      check("hold tag", 64'(bus.out_tag), 64'(9));
      check("hold in_ready", 64'(bus.in_ready), 64'(0));
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold release valid", 64'(bus.out_valid), 64'(0));
    check("hold release in_ready", 64'(bus.in_ready), 64'(1));

    // Flush at cycle 10 of a DIVU, with in_valid still asserted during the flush.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 5'd17; bus.in_src1 = 32'd1000; bus.in_src2 = 32'd3;
    bus.in_tag = 4'h3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
    @(negedge clk);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_op = 5'd1;
    #1 check("flush in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    highs = 0;
    for (int i = 0; i < W + 10; i++) begin
      if (bus.out_valid) highs++;
      @(posedge clk); #1;
    end
    check("flush dropped", 64'(highs), 64'(0));
    run_op("after_flush", 1, 32'd1, 32'd2, 4'h1);

    // Reset pulse while a multiply is in flight.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 5'd13; bus.in_src1 = 32'd7; bus.in_src2 = 32'd9;
    bus.in_tag = 4'hF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst out_valid", 64'(bus.out_valid), 64'(0));
    check("rst out_result", 64'(bus.out_result), 64'(0));
    check("rst out_tag", 64'(bus.out_tag), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) highs++;
    end
    check("rst dropped", 64'(highs), 64'(0));
    run_op("after_rst", 1, 32'd1, 32'd2, 4'h2);

    // Randomized ops, biased toward small and zero divisors and the MIN/-1 corner.
    for (int i = 0; i < 50; i++) begin
      rop = int'($urandom_range(0, 31));
      ra  = $urandom;
      rb  = $urandom;
      k   = int'($urandom_range(0, 7));
      if (k == 0) rb = '0;
      else if (k == 1) rb = W'($urandom_range(1, 15));
      else if (k == 2) begin ra = MIN; rb = '1; end
      else if (k == 3) ra = W'($urandom_range(0, 100));
      if (i % 3 == 0) rop = int'($urandom_range(13, 19));
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, TW'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule
